// File: rtl/chip8_pkg.sv
// chip8_pkg: shared screen/keypad constants, framebuffer type and pixel-index helper
package chip8_pkg;
  localparam int SCREEN_W = 64;
  localparam int SCREEN_H = 32;
  localparam int FB_BITS = SCREEN_W * SCREEN_H;
  localparam int KEY_COUNT = 16;
  typedef logic [FB_BITS-1:0] fb_t;
  function automatic logic [10:0] pix_idx(input logic [4:0] row, input logic [5:0] col);
    return 11'(int'(row) * SCREEN_W + int'(col));
  endfunction
endpackage

// File: rtl/chip8_io_unit_if.sv
// chip8_io_unit_if: sprite-row draw bus between the CPU/top level and the I/O unit
interface chip8_io_unit_if;
  import chip8_pkg::*;
  logic draw;
  logic [5:0] x;
  logic [4:0] y;
  logic [3:0] row_index;
  logic [7:0] sprite_data;
  fb_t display_in;
  fb_t display_out;
  logic collision;
  modport master (output draw, x, y, row_index, sprite_data, display_in, input display_out, collision);
  modport slave (input draw, x, y, row_index, sprite_data, display_in, output display_out, collision);
endinterface

// File: rtl/chip8_key_sync.sv
// chip8_key_sync: keypad synchronizer chain plus pressed/lowest-key encoder
module chip8_key_sync
  import chip8_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [KEY_COUNT-1:0] keys_raw,
  output logic [KEY_COUNT-1:0] key_state,
  output logic                 key_pressed,
  output logic [3:0]           key_index
);
  logic [KEY_COUNT-1:0] stage [SYNC_STAGES];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) stage[s] <= '0;
    end else begin
      stage[0] <= keys_raw;
      for (int s = 1; s < SYNC_STAGES; s++) stage[s] <= stage[s-1];
    end
  end
  assign key_state = stage[SYNC_STAGES-1];
  assign key_pressed = |key_state;
  // descending scan so the lowest pressed key is the last (winning) assignment
  always_comb begin
    key_index = '0;
    for (int k = KEY_COUNT - 1; k >= 0; k--) if (key_state[k]) key_index = 4'(k);
  end
endmodule

// File: rtl/chip8_io_unit.sv
// chip8_io_unit: keypad sync and XOR sprite-row draw with collision; CHIP8_SPRITE_CLIP_EN clips instead of wrapping
module chip8_io_unit
  import chip8_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [KEY_COUNT-1:0] keys_raw,
  output logic [KEY_COUNT-1:0] key_state,
  output logic                 key_pressed,
  output logic [3:0]           key_index,
  chip8_io_unit_if.slave       bus
);
  chip8_key_sync #(.SYNC_STAGES(SYNC_STAGES)) u_key_sync (
    .clk(clk),
    .reset(reset),
    .keys_raw(keys_raw),
    .key_state(key_state),
    .key_pressed(key_pressed),
    .key_index(key_index)
  );
  logic [4:0] row;
  logic [7:0] en;
  logic [7:0] hit;
  logic [10:0] idx [8];
  assign row = bus.y + 5'(bus.row_index);
`ifdef CHIP8_SPRITE_CLIP_EN
  logic row_ok;
  assign row_ok = ({1'b0, bus.y} + 6'(bus.row_index)) < 6'd32;
`endif
  genvar i;
  generate
    for (i = 0; i < 8; i++) begin : g_pix
      logic [5:0] col;
      assign col = bus.x + 6'(i);
`ifdef CHIP8_SPRITE_CLIP_EN
      assign en[i] = bus.draw & bus.sprite_data[7-i] & row_ok & ((7'(bus.x) + 7'(i)) < 7'd64);
`else
      assign en[i] = bus.draw & bus.sprite_data[7-i];
`endif
      assign idx[i] = pix_idx(row, col);
      assign hit[i] = en[i] & bus.display_in[idx[i]];
    end
  endgenerate
  assign bus.collision = |hit;
  // the 8 columns are distinct mod 64, so each enabled pixel toggles exactly once
  always_comb begin
    bus.display_out = bus.display_in;
    for (int k = 0; k < 8; k++) if (en[k]) bus.display_out[idx[k]] = ~bus.display_in[idx[k]];
  end
endmodule

// File: tb/tb_chip8_io_unit.sv
// tb_chip8_io_unit: randomized keypad and sprite-draw checks against a behavioural model
module tb_chip8_io_unit;
  import chip8_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] keys_raw = '0;
  logic [15:0] key_state;
  logic key_pressed;
  logic [3:0] key_index;
  int checks = 0;
  int errors = 0;
  logic [15:0] hist [$];
  chip8_io_unit_if bus ();
  chip8_io_unit #(.SYNC_STAGES(2)) dut (
    .clk(clk),
    .reset(reset),
    .keys_raw(keys_raw),
    .key_state(key_state),
    .key_pressed(key_pressed),
    .key_index(key_index),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;

  // model: key_state shows the keys seen two edges ago; a reset edge empties the pipeline
  task automatic tick;
    @(posedge clk);
    if (reset) begin
      hist.delete();
      hist.push_back(16'h0);
      hist.push_back(16'h0);
    end else begin
      hist.push_back(keys_raw);
      void'(hist.pop_front());
    end
    #1;
  endtask

  function automatic logic [3:0] low_key(input logic [15:0] k);
    for (int n = 0; n < 16; n++) if (k[n]) return 4'(n);
    return 4'd0;
  endfunction

  function automatic fb_t rand_fb();
    fb_t v;
    for (int n = 0; n < FB_BITS / 32; n++) v[n*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic ref_draw(input fb_t din, input logic d, input int xx, input int yy, input int rr,
                          input logic [7:0] s, output fb_t dout, output logic c);
    dout = din;
    c = 1'b0;
    if (!d) return;
    for (int p = 0; p < 8; p++) begin
      int col, r;
      col = xx + p;
      r = yy + rr;
`ifdef CHIP8_SPRITE_CLIP_EN
      if (col > 63 || r > 31) continue;
`else
      col = col % 64;
      r = r % 32;
`endif
      if (s[7-p]) begin
        if (din[r*64+col]) c = 1'b1;
        dout[r*64+col] = ~dout[r*64+col];
      end
    end
  endtask

  task automatic apply_draw(input fb_t din, input logic d, input int xx, input int yy, input int rr, input logic [7:0] s);
    bus.display_in = din;
    bus.draw = d;
    bus.x = 6'(xx);
    bus.y = 5'(yy);
    bus.row_index = 4'(rr);
    bus.sprite_data = s;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    keys_raw = 16'h0000;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks += 3;
    if (key_state !== 16'h0) begin errors++; $display("FAIL reset key_state got %h want 0000", key_state); end
    if (key_pressed !== 1'b0) begin errors++; $display("FAIL reset key_pressed got %b want 0", key_pressed); end
    if (key_index !== 4'd0) begin errors++; $display("FAIL reset key_index got %0d want 0", key_index); end
  endtask

  task automatic test_key_latency;
    keys_raw = 16'h0028;
    tick();
    checks++;
    if (key_state !== 16'h0) begin errors++; $display("FAIL latency1 key_state got %h want 0000", key_state); end
    tick();
    checks += 3;
    if (key_state !== 16'h0028) begin errors++; $display("FAIL latency2 key_state got %h want 0028", key_state); end
    if (key_pressed !== 1'b1) begin errors++; $display("FAIL latency2 key_pressed got %b want 1", key_pressed); end
    if (key_index !== 4'd3) begin errors++; $display("FAIL latency2 key_index got %0d want 3", key_index); end
  endtask

  task automatic test_key_random;
    for (int t = 0; t < 60; t++) begin
      int mode;
      mode = $urandom_range(0, 3);
      keys_raw = mode == 0 ? 16'h0 : mode == 1 ? 16'(1 << $urandom_range(0, 15)) : 16'($urandom);
      repeat ($urandom_range(1, 3)) begin
        tick();
        checks += 3;
        if (key_state !== hist[0]) begin errors++; $display("FAIL key_rand[%0d] key_state got %h want %h", t, key_state, hist[0]); end
        if (key_pressed !== (hist[0] != 16'h0)) begin errors++; $display("FAIL key_rand[%0d] key_pressed got %b want %b", t, key_pressed, hist[0] != 16'h0); end
        if (key_index !== low_key(hist[0])) begin errors++; $display("FAIL key_rand[%0d] key_index got %0d want %0d", t, key_index, low_key(hist[0])); end
      end
    end
  endtask

  task automatic test_reset_midflight;
    keys_raw = 16'hFFFF;
    tick();
    tick();
    keys_raw = 16'h1234;
    tick();
    reset = 1'b1;
    keys_raw = 16'hFFFF;
    tick();
    checks++;
    if (key_state !== 16'h0) begin errors++; $display("FAIL midreset key_state got %h want 0000", key_state); end
    reset = 1'b0;
    tick();
    checks++;
    if (key_state !== 16'h0) begin errors++; $display("FAIL midreset+1 key_state got %h want 0000", key_state); end
    tick();
    checks++;
    if (key_state !== 16'hFFFF) begin errors++; $display("FAIL midreset+2 key_state got %h want ffff", key_state); end
  endtask

  task automatic test_draw_basic;
    fb_t first, want;
    want = '0;
    want[3:0] = 4'hF;
    apply_draw('0, 1'b1, 0, 0, 0, 8'hF0);
    first = bus.display_out;
    checks += 2;
    if (bus.display_out !== want) begin errors++; $display("FAIL draw_f0 display_out differs in %0d bits", $countones(bus.display_out ^ want)); end
    if (bus.collision !== 1'b0) begin errors++; $display("FAIL draw_f0 collision got %b want 0", bus.collision); end
    apply_draw(first, 1'b1, 0, 0, 0, 8'hF0);
    checks += 2;
    if (bus.display_out !== '0) begin errors++; $display("FAIL redraw_f0 display_out has %0d bits set want 0", $countones(bus.display_out)); end
    if (bus.collision !== 1'b1) begin errors++; $display("FAIL redraw_f0 collision got %b want 1", bus.collision); end
  endtask

  task automatic test_draw_wrap;
    fb_t want;
    want = '0;
`ifndef CHIP8_SPRITE_CLIP_EN
    want[63:60] = 4'hF;
    want[3:0] = 4'hF;
`endif
    apply_draw('0, 1'b1, 60, 31, 1, 8'hFF);
    checks += 2;
    if (bus.display_out !== want) begin errors++; $display("FAIL draw_wrap display_out differs in %0d bits", $countones(bus.display_out ^ want)); end
    if (bus.collision !== 1'b0) begin errors++; $display("FAIL draw_wrap collision got %b want 0", bus.collision); end
  endtask

  task automatic test_draw_idle;
    for (int t = 0; t < 4; t++) begin
      fb_t din;
      din = rand_fb();
      apply_draw(din, 1'b0, $urandom_range(0, 63), $urandom_range(0, 31), $urandom_range(0, 15), 8'hFF);
      checks += 2;
      if (bus.display_out !== din) begin errors++; $display("FAIL draw_idle[%0d] display_out differs in %0d bits", t, $countones(bus.display_out ^ din)); end
      if (bus.collision !== 1'b0) begin errors++; $display("FAIL draw_idle[%0d] collision got %b want 0", t, bus.collision); end
    end
  endtask

  task automatic test_draw_random;
    for (int t = 0; t < 80; t++) begin
      fb_t din, want;
      logic c;
      int xx, yy, rr;
      logic [7:0] s;
      din = $urandom_range(0, 3) == 0 ? fb_t'(0) : rand_fb();
      xx = $urandom_range(0, 3) == 0 ? $urandom_range(56, 63) : $urandom_range(0, 63);
      yy = $urandom_range(0, 31);
      rr = $urandom_range(0, 15);
      s = $urandom_range(0, 7) == 0 ? 8'h00 : 8'($urandom);
      ref_draw(din, 1'b1, xx, yy, rr, s, want, c);
      apply_draw(din, 1'b1, xx, yy, rr, s);
      checks += 2;
      if (bus.display_out !== want) begin errors++; $display("FAIL draw_rand[%0d] x=%0d y=%0d r=%0d s=%h display_out differs in %0d bits", t, xx, yy, rr, s, $countones(bus.display_out ^ want)); end
      if (bus.collision !== c) begin errors++; $display("FAIL draw_rand[%0d] x=%0d y=%0d r=%0d s=%h collision got %b want %b", t, xx, yy, rr, s, bus.collision, c); end
    end
  endtask

  initial begin
    bus.draw = 1'b0;
    bus.x = '0;
    bus.y = '0;
    bus.row_index = '0;
    bus.sprite_data = '0;
    bus.display_in = '0;
    test_reset();
    test_key_latency();
    test_key_random();
    test_reset_midflight();
    test_draw_basic();
    test_draw_wrap();
    test_draw_idle();
    test_draw_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
